// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game flow controller for a pacman-style game.
// Tracks the level state (IDLE/PLAY/DYING/CLEAR/OVER), lives, score and the
// pellet count for the current level. It also flags ghost/pacman collisions
// per ghost.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   start             : level-sensitive start / restart / next-level request
//   food_eaten        : one-cycle pulse per pellet consumed
//   pacman_x/_y       : pacman pixel position (11 / 10 bits)
//   ghost_x/_y        : packed ghost positions, ghost i at [11i+10:11i] / [10i+9:10i]
//   state             : IDLE=0 PLAY=1 DYING=2 CLEAR=3 OVER=4
//   run               : sprite movement enable, high only in PLAY
//   respawn           : one-cycle pulse telling sprites to reset positions
//   lives_left, score : game counters
//   hit_mask          : registered per-ghost collision flags
module game_state_ctrl #(
  parameter int NUM_GHOSTS  = 4,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 12,
  parameter int FOOD_TOTAL  = 300,
  parameter int HIT_DIST    = 8,
  parameter int RESPAWN_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    food_eaten,
  input  logic [10:0]             pacman_x,
  input  logic [9:0]              pacman_y,
  input  logic [11*NUM_GHOSTS-1:0] ghost_x,
  input  logic [10*NUM_GHOSTS-1:0] ghost_y,
  output logic [2:0]              state,
  output logic                    run,
  output logic                    respawn,
  output logic [2:0]              lives_left,
  output logic [SCORE_W-1:0]      score,
  output logic [NUM_GHOSTS-1:0]   hit_mask
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int DCW = (RESPAWN_CYC > 2) ? $clog2(RESPAWN_CYC) : 1;

  state_t             st;
  logic [SCORE_W-1:0] food_cnt;
  logic [DCW-1:0]     dcnt;
  logic [NUM_GHOSTS-1:0] hit_d;

  assign state = st;

  // Per-ghost collision: unsigned absolute difference on each axis, so the
  // screen edges never wrap into a false hit.
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
    logic [10:0] gx, dx;
    logic [9:0]  gy, dy;
    assign gx = ghost_x[11*g +: 11];
    assign gy = ghost_y[10*g +: 10];
    assign dx = (pacman_x >= gx) ? pacman_x - gx : gx - pacman_x;
    assign dy = (pacman_y >= gy) ? pacman_y - gy : gy - pacman_y;
    assign hit_d[g] = (32'(dx) < HIT_DIST) && (32'(dy) < HIT_DIST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      run        <= 1'b0;
      respawn    <= 1'b0;
      lives_left <= '0;
      score      <= '0;
      food_cnt   <= '0;
      dcnt       <= '0;
      hit_mask   <= '0;
    end else begin
      hit_mask <= hit_d;
      respawn  <= 1'b0;
      run      <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (start) begin
            lives_left <= 3'(LIVES);
            score      <= '0;
            food_cnt   <= '0;
            respawn    <= 1'b1;
            run        <= 1'b1;
            st         <= S_PLAY;
          end
        end
        S_CLEAR: begin
          // Next level: score and lives carry over.
          if (start) begin
            food_cnt <= '0;
            respawn  <= 1'b1;
            run      <= 1'b1;
            st       <= S_PLAY;
          end
        end
        S_PLAY: begin
          run <= 1'b1;
          if (food_eaten) begin
            food_cnt <= food_cnt + 1'b1;
            if (score != '1) score <= score + 1'b1;
          end
          // A level-completing pellet beats a same-cycle hit.
          if (food_eaten && food_cnt == SCORE_W'(FOOD_TOTAL - 1)) begin
            run <= 1'b0;
            st  <= S_CLEAR;
          end else if (|hit_mask) begin
            lives_left <= lives_left - 1'b1;
            dcnt       <= '0;
            run        <= 1'b0;
            st         <= S_DYING;
          end
        end
        S_DYING: begin
          if (dcnt == DCW'(RESPAWN_CYC - 1)) begin
            dcnt <= '0;
            if (lives_left != '0) begin
              respawn <= 1'b1;
              run     <= 1'b1;
              st      <= S_PLAY;
            end else begin
              st <= S_OVER;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
